// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Two-requester round-robin burst arbiter sharing the write port of the
//   pixel FIFO. Requester 0 is the frame-buffer fetch engine, requester 1 the
//   overlay/command path. A grant lasts up to MAX_BURST accepted words; every
//   burst is preceded by one arbitration cycle in IDLE.
//
// Ports
//   i_clock, i_reset        clock, synchronous active-high reset
//   i_req0/i_data0/o_ack0   requester 0 handshake (ack = word taken this cycle)
//   i_req1/i_data1/o_ack1   requester 1 handshake
//   o_fifoData/o_fifoValid  FIFO write data and strobe
//   i_fifoFull              FIFO full flag; stalls the burst without timeout
//   o_grant                 one-hot owner, 2'b00 when idle
//   o_busy                  high while a burst is in progress
//   o_count0/o_count1       saturating per-requester word counts, present only
//                           when FIFO_WRITE_ARBITER_STATS_EN is defined
//
// state  | meaning
// IDLE   | no owner; pick next owner (1-cycle arbitration gap, no word taken)
// BURST0 | requester 0 owns the FIFO write port
// BURST1 | requester 1 owns the FIFO write port

module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_req0,
  input  logic [DATA_WIDTH-1:0] i_data0,
  output logic                  o_ack0,
  input  logic                  i_req1,
  input  logic [DATA_WIDTH-1:0] i_data1,
  output logic                  o_ack1,
  output logic [DATA_WIDTH-1:0] o_fifoData,
  output logic                  o_fifoValid,
  input  logic                  i_fifoFull,
  output logic [1:0]            o_grant,
  output logic                  o_busy
`ifdef FIFO_WRITE_ARBITER_STATS_EN
  ,
  output logic [15:0]           o_count0,
  output logic [15:0]           o_count1
`endif
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BURST0 = 2'd1,
    S_BURST1 = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d;   // index of the most recently granted requester
  logic            own1;
  logic            cur_req;
  logic            accept;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    own1        = 1'b0;
    cur_req     = 1'b0;
    accept      = 1'b0;
    o_ack0      = 1'b0;
    o_ack1      = 1'b0;
    o_fifoData  = '0;
    o_fifoValid = 1'b0;
    o_grant     = 2'b00;
    o_busy      = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // On a tie the requester that did not own the last burst wins.
        if (i_req0 && i_req1) begin
          if (last_q) begin
            state_d = S_BURST0;
            last_d  = 1'b0;
          end else begin
            state_d = S_BURST1;
            last_d  = 1'b1;
          end
        end else if (i_req0) begin
          state_d = S_BURST0;
          last_d  = 1'b0;
        end else if (i_req1) begin
          state_d = S_BURST1;
          last_d  = 1'b1;
        end
      end

      S_BURST0, S_BURST1: begin
        own1        = (state_q == S_BURST1);
        cur_req     = own1 ? i_req1 : i_req0;
        accept      = cur_req & ~i_fifoFull;
        o_grant     = own1 ? 2'b10 : 2'b01;
        o_busy      = 1'b1;
        o_fifoData  = own1 ? i_data1 : i_data0;
        o_fifoValid = accept;
        o_ack0      = accept & ~own1;
        o_ack1      = accept & own1;
        // A dropped request ends the burst; full only stalls it.
        if (!cur_req) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (accept) begin
          if (cnt_q == LAST_CNT) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Nothing is accepted or presented while reset is held.
    if (i_reset) begin
      accept      = 1'b0;
      o_ack0      = 1'b0;
      o_ack1      = 1'b0;
      o_fifoData  = '0;
      o_fifoValid = 1'b0;
      o_grant     = 2'b00;
      o_busy      = 1'b0;
    end
  end

`ifdef FIFO_WRITE_ARBITER_STATS_EN
  logic [15:0] count0_q, count1_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      count0_q <= '0;
      count1_q <= '0;
    end else begin
      if (o_ack0 && (count0_q != 16'hFFFF)) count0_q <= count0_q + 16'd1;
      if (o_ack1 && (count1_q != 16'hFFFF)) count1_q <= count1_q + 16'd1;
    end
  end

  assign o_count0 = count0_q;
  assign o_count1 = count1_q;
`endif

endmodule
